// File: rtl/instruction_fetch_pkg.sv
// Shared CPU definitions for the fetch stage and its neighbours.
//   NOP_INSTR        : bubble encoding (sll $0,$0,0)
//   PC_STEP          : sequential PC increment in bytes
//   DEFAULT_RESET_PC : byte address fetched first after reset
//   IMM_W/JTARGET_W  : I-type immediate and J-type target field widths
//   word_align()     : clears bits[1:0] of a byte address
package instruction_fetch_pkg;

   localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
   localparam logic [31:0] PC_STEP          = 32'd4;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
   localparam int          IMM_W            = 16;
   localparam int          JTARGET_W        = 26;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & ~32'h0000_0003;
   endfunction

endpackage

// File: rtl/instruction_fetch_next_pc.sv
// fetch_next_pc: combinational next-PC select for the fetch stage.
// Ports:
//   pc            in  32        current fetch PC
//   if_pc_plus4   in  32        PC+4 of the instruction held in IF/ID (branch/jump base)
//   branch_taken  in  1         take branch: if_pc_plus4 + sext(branch_offset)*4
//   branch_offset in  IMM_W     signed word offset
//   jump          in  1         J-type: {if_pc_plus4[31:28], jump_target, 2'b00}
//   jump_target   in  JTARGET_W J-type target field
//   jump_reg      in  1         jr: reg_target with bits[1:0] cleared
//   reg_target    in  32        register value for jr
//   next_pc       out 32        selected next PC (sequential when no redirect)
//   redirect      out 1         any redirect is active this cycle
module fetch_next_pc
   import instruction_fetch_pkg::*;
(
   input  logic [31:0]          pc,
   input  logic [31:0]          if_pc_plus4,
   input  logic                 branch_taken,
   input  logic [IMM_W-1:0]     branch_offset,
   input  logic                 jump,
   input  logic [JTARGET_W-1:0] jump_target,
   input  logic                 jump_reg,
   input  logic [31:0]          reg_target,
   output logic [31:0]          next_pc,
   output logic                 redirect
);

   // Word offset sign-extended to 32 bits, then scaled to bytes.
   logic signed [31:0] branch_disp;
   assign branch_disp = {{(32-IMM_W-2){branch_offset[IMM_W-1]}}, branch_offset, 2'b00};

   // Redirect priority: jr over j over taken branch.
   always_comb begin
      next_pc  = word_align(pc + PC_STEP);
      redirect = 1'b0;
      if (jump_reg) begin
         next_pc  = word_align(reg_target);
         redirect = 1'b1;
      end else if (jump) begin
         next_pc  = {if_pc_plus4[31:28], jump_target, 2'b00};
         redirect = 1'b1;
      end else if (branch_taken) begin
         next_pc  = word_align(if_pc_plus4 + $unsigned(branch_disp));
         redirect = 1'b1;
      end
   end

endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC register plus IF/ID pipeline register feeding decode.
// Ports:
//   clk           in  1          posedge clock
//   reset         in  1          asynchronous, active-high
//   mem_addr      out ADDR_WIDTH word address to instruction memory (from pc)
//   mem_data      in  32         combinational memory read data for mem_addr
//   stall         in  1          hold pc and IF/ID
//   branch_taken  in  1          redirect to if_pc_plus4 + sext(branch_offset)*4
//   branch_offset in  16         signed word offset
//   jump          in  1          redirect to {if_pc_plus4[31:28], jump_target, 2'b00}
//   jump_target   in  26         J-type target field
//   jump_reg      in  1          redirect to reg_target with bits[1:0] cleared
//   reg_target    in  32         jr register value
//   pc_out        out 32         current fetch PC
//   if_instr      out 32         IF/ID instruction (NOP when bubble)
//   if_pc_plus4   out 32         IF/ID PC+4 of if_instr
//   if_valid      out 1          IF/ID holds a real instruction
module instruction_fetch
   import instruction_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
   parameter int          ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  reset,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [31:0]           mem_data,
   input  logic                  stall,
   input  logic                  branch_taken,
   input  logic [IMM_W-1:0]      branch_offset,
   input  logic                  jump,
   input  logic [JTARGET_W-1:0]  jump_target,
   input  logic                  jump_reg,
   input  logic [31:0]           reg_target,
   output logic [31:0]           pc_out,
   output logic [31:0]           if_instr,
   output logic [31:0]           if_pc_plus4,
   output logic                  if_valid
);

   logic [31:0] pc_p0;
   logic [31:0] instr_p1;
   logic [31:0] pc_plus4_p1;
   logic        vld_p1;
   logic [31:0] next_pc;
   logic        redirect;

   fetch_next_pc u_next_pc (
      .pc            (pc_p0),
      .if_pc_plus4   (pc_plus4_p1),
      .branch_taken  (branch_taken),
      .branch_offset (branch_offset),
      .jump          (jump),
      .jump_target   (jump_target),
      .jump_reg      (jump_reg),
      .reg_target    (reg_target),
      .next_pc       (next_pc),
      .redirect      (redirect)
   );

   // Upper pc bits are dropped here: memory aliases at 2^ADDR_WIDTH words.
   assign mem_addr = pc_p0[ADDR_WIDTH+1:2];

   // Stage p0 -> p1: fetch PC register and IF/ID capture.
   // A redirect beats stall and flushes the word fetched this cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_p0       <= word_align(RESET_PC);
         instr_p1    <= NOP_INSTR;
         pc_plus4_p1 <= 32'h0;
         vld_p1      <= 1'b0;
      end else if (redirect) begin
         pc_p0       <= next_pc;
         instr_p1    <= NOP_INSTR;
         pc_plus4_p1 <= 32'h0;
         vld_p1      <= 1'b0;
      end else if (!stall) begin
         pc_p0       <= next_pc;
         instr_p1    <= mem_data;
         pc_plus4_p1 <= pc_p0 + PC_STEP;
         vld_p1      <= 1'b1;
      end
   end

   assign pc_out      = pc_p0;
   assign if_instr    = instr_p1;
   assign if_pc_plus4 = pc_plus4_p1;
   assign if_valid    = vld_p1;

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

   logic        clk = 1'b0;
   logic        reset;
   logic [9:0]  mem_addr, mem_addr2;
   logic [31:0] mem_data, mem_data2;
   logic        stall, branch_taken, jump, jump_reg;
   logic [15:0] branch_offset;
   logic [25:0] jump_target;
   logic [31:0] reg_target;
   logic [31:0] pc_out, if_instr, if_pc_plus4;
   logic        if_valid;
   logic [31:0] pc_out2, if_instr2, if_pc_plus42;
   logic        if_valid2;

   logic [31:0] mem [1024];

   assign mem_data  = mem[mem_addr];
   assign mem_data2 = mem[mem_addr2];

   always #5 clk = ~clk;

   instruction_fetch #(.RESET_PC(32'h0000_0000), .ADDR_WIDTH(10)) dut (
      .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_data(mem_data),
      .stall(stall), .branch_taken(branch_taken), .branch_offset(branch_offset),
      .jump(jump), .jump_target(jump_target), .jump_reg(jump_reg),
      .reg_target(reg_target), .pc_out(pc_out), .if_instr(if_instr),
      .if_pc_plus4(if_pc_plus4), .if_valid(if_valid)
   );

   // Second instance starting at the last memory word, free-running.
   instruction_fetch #(.RESET_PC(32'h0000_0FFC), .ADDR_WIDTH(10)) dut_wrap (
      .clk(clk), .reset(reset), .mem_addr(mem_addr2), .mem_data(mem_data2),
      .stall(1'b0), .branch_taken(1'b0), .branch_offset(16'h0),
      .jump(1'b0), .jump_target(26'h0), .jump_reg(1'b0),
      .reg_target(32'h0), .pc_out(pc_out2), .if_instr(if_instr2),
      .if_pc_plus4(if_pc_plus42), .if_valid(if_valid2)
   );

   typedef struct packed {
      logic [31:0] pc;
      logic        valid;
      logic [31:0] instr;
      logic [31:0] pc4;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;
   logic chk_en   = 1'b0;

   // Reference state: fetch PC and what IF/ID should hold.
   logic [31:0] m_pc, m_instr, m_pc4;
   logic        m_valid;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] byte_addr);
      return mem[int'((byte_addr / 4) % 1024)];
   endfunction

   task automatic model_reset();
      m_pc    = 32'h0;
      m_instr = 32'h0;
      m_pc4   = 32'h0;
      m_valid = 1'b0;
   endtask

   // Drive one cycle of controls and record the state expected after the next edge.
   task automatic step(input logic s, input logic b, input logic [15:0] off,
                       input logic j, input logic [25:0] jt,
                       input logic jr, input logic [31:0] rt);
      exp_t e;
      int   o;
      @(negedge clk);
      stall = s; branch_taken = b; branch_offset = off;
      jump = j; jump_target = jt; jump_reg = jr; reg_target = rt;
      if (jr || j || b) begin
         if (jr)     m_pc = (rt / 4) * 4;
         else if (j) m_pc = (m_pc4 & 32'hF000_0000) + {4'h0, jt, 2'b00};
         else begin
            o    = int'($signed(off));
            m_pc = m_pc4 + 32'(o * 4);
         end
         m_instr = 32'h0;
         m_pc4   = 32'h0;
         m_valid = 1'b0;
      end else if (!s) begin
         m_instr = mem_word(m_pc);
         m_pc4   = m_pc + 32'd4;
         m_valid = 1'b1;
         m_pc    = m_pc + 32'd4;
      end
      e.pc = m_pc; e.valid = m_valid; e.instr = m_instr; e.pc4 = m_pc4;
      exp_q.push_back(e);
      chk_en = 1'b1;
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0);
   endtask

   task automatic settle();
      @(posedge clk);
      #2;
   endtask

   // Monitor: the DUT presents a new IF/ID state every cycle; compare it.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (chk_en) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_empty actual=0 required=1 entry at %0t", $time);
         end else begin
            e = exp_q.pop_front();
            check("sb_pc",       pc_out,                     e.pc);
            check("sb_mem_addr", {22'h0, mem_addr},          {22'h0, e.pc[11:2]});
            check("sb_valid",    {31'h0, if_valid},          {31'h0, e.valid});
            check("sb_instr",    if_instr,                   e.instr);
            check("sb_pc4",      if_pc_plus4,                e.pc4);
         end
      end
   end

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = $urandom;
      reset = 1'b1;
      stall = 1'b0; branch_taken = 1'b0; branch_offset = 16'h0;
      jump = 1'b0; jump_target = 26'h0; jump_reg = 1'b0; reg_target = 32'h0;
      model_reset();

      // Reset state of both instances.
      #12;
      check("rst_pc",        pc_out,                 32'h0);
      check("rst_valid",     {31'h0, if_valid},      32'h0);
      check("rst_instr",     if_instr,               32'h0);
      check("wrap_rst_pc",   pc_out2,                32'h0000_0FFC);
      check("wrap_rst_addr", {22'h0, mem_addr2},     32'h0000_03FF);
      @(posedge clk); #1;
      reset = 1'b0;

      // Sequential fetch, wrap instance crosses the memory boundary.
      idle(); settle();
      check("wrap_pc",    pc_out2,              32'h0000_1000);
      check("wrap_addr",  {22'h0, mem_addr2},   32'h0);
      check("wrap_instr", if_instr2,            mem[1023]);
      check("wrap_pc4",   if_pc_plus42,         32'h0000_1000);
      idle(); idle(); settle();
      check("seq_instr2", if_instr,    mem[2]);
      check("seq_pc4_12", if_pc_plus4, 32'd12);

      // Reset mid-run while stalling: clears in the same timestep.
      step(1'b1, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0); settle();
      chk_en = 1'b0;
      exp_q.delete();
      #1 reset = 1'b1;
      #1;
      check("mid_rst_pc",    pc_out,               32'h0);
      check("mid_rst_addr",  {22'h0, mem_addr},    32'h0);
      check("mid_rst_valid", {31'h0, if_valid},    32'h0);
      check("mid_rst_pc4",   if_pc_plus4,          32'h0);
      stall = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      model_reset();

      idle(); settle();
      check("first_instr", if_instr, mem[0]);
      check("first_pc4",   if_pc_plus4, 32'd4);
      idle(); settle();
      check("pre_stall_pc", pc_out, 32'd8);

      // Stall two cycles at pc=8, then release.
      step(1'b1, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0);
      step(1'b1, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0); settle();
      check("stall_pc",  pc_out,      32'd8);
      check("stall_pc4", if_pc_plus4, 32'd8);
      idle(); settle();
      check("release_instr", if_instr,    mem[2]);
      check("release_pc4",   if_pc_plus4, 32'd12);

      // Backward branch from if_pc_plus4=12.
      step(1'b0, 1'b1, 16'hFFFE, 1'b0, 26'h0, 1'b0, 32'h0); settle();
      check("br_pc",    pc_out,            32'd4);
      check("br_valid", {31'h0, if_valid}, 32'h0);
      idle(); settle();
      check("br_instr", if_instr, mem[1]);

      // Jump, jr, and jr winning over a simultaneous jump.
      step(1'b0, 1'b0, 16'h0, 1'b1, 26'h10, 1'b0, 32'h0); settle();
      check("j_pc", pc_out, 32'h40);
      step(1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b1, 32'h23); settle();
      check("jr_pc", pc_out, 32'h20);
      step(1'b0, 1'b0, 16'h0, 1'b1, 26'h10, 1'b1, 32'h84); settle();
      check("jr_over_j_pc", pc_out, 32'h84);

      // Redirect together with stall from if_pc_plus4=8.
      step(1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b1, 32'h4);
      idle();
      step(1'b1, 1'b1, 16'h0003, 1'b0, 26'h0, 1'b0, 32'h0); settle();
      check("br_stall_pc",    pc_out,            32'd20);
      check("br_stall_valid", {31'h0, if_valid}, 32'h0);

      // 32-bit PC wrap and memory aliasing.
      step(1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b1, 32'hFFFF_FFFC); settle();
      check("top_addr", {22'h0, mem_addr}, 32'h3FF);
      idle(); settle();
      check("pc_wrap",     pc_out,      32'h0);
      check("pc_wrap_pc4", if_pc_plus4, 32'h0);
      check("pc_wrap_instr", if_instr,  mem[1023]);

      // Randomized control traffic.
      for (int n = 0; n < 400; n++) begin
         step(($urandom % 5) == 0, ($urandom % 10) == 0, 16'($urandom),
              ($urandom % 20) == 0, 26'($urandom),
              ($urandom % 20) == 0, $urandom);
      end
      settle();
      chk_en = 1'b0;
      check("sb_drained", 32'(exp_q.size()), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
